// File: rtl/st2bus_pkg.sv
// Shared types and constants for the Avalon-ST to bus-word packer.
package st2bus_pkg;

  // Beats per bus word and width of a lane count (1..BEATS) for the
  // default 8-bit beat / 512-bit word configuration.
  localparam int BEATS = 64;
  localparam int CNT_W = $clog2(BEATS + 1);

  // Tags carried alongside every buffered word.
  typedef struct packed {
    logic             last;
    logic             err;
    logic [CNT_W-1:0] nbeats;
  } word_tag_t;

  // Packer states. FLUSH emits a one-beat packet whose sop+eop beat
  // arrived in the same cycle that a truncated word was pushed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PKT   = 2'd1,
    ST_FLUSH = 2'd2
  } pk_state_e;

  function automatic word_tag_t make_tag(input logic last, input logic err,
                                         input logic [CNT_W-1:0] nbeats);
    word_tag_t t;
    t.last   = last;
    t.err    = err;
    t.nbeats = nbeats;
    return t;
  endfunction

endpackage

// File: rtl/st2bus_word_fifo.sv
// Show-ahead word FIFO with tags. The head entry is visible on head_*
// whenever empty is low. retag sets last/err on the most recently pushed
// entry, unless that entry leaves the FIFO in the same cycle.
module st2bus_word_fifo
  import st2bus_pkg::*;
#(
  parameter  int W     = 512,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  word_tag_t     push_tag,
  input  logic          pop,
  input  logic          retag,
  output logic [W-1:0]  head_data,
  output word_tag_t     head_tag,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  data_mem [DEPTH];
  word_tag_t     tag_mem  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] last_ptr;
  logic          do_pop;
  logic          retag_ok;
  logic [LW-1:0] level_after_pop;

  assign do_pop          = pop && (level != '0);
  assign level_after_pop = level - LW'(do_pop);
  assign retag_ok        = retag && (level_after_pop != '0);
  assign last_ptr        = wr_ptr - AW'(1);

  // Word storage: written on push only, never reset (reads are masked upstream).
  always_ff @(posedge clk) begin
    if (push) data_mem[wr_ptr] <= push_data;
  end

  // Tag storage: push writes a fresh tag, retag marks the newest entry.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= push_tag;
    if (retag_ok) begin
      tag_mem[last_ptr].last <= 1'b1;
      tag_mem[last_ptr].err  <= 1'b1;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(do_pop);
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_tag  = tag_mem[rd_ptr];
  assign empty     = (level == '0);

  // The upstream ready margin must keep pushes away from a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (level == LW'(DEPTH))));

endmodule

// File: rtl/st2bus_packer.sv
// Packs sop/eop framed Avalon-ST beats into BUS_W-bit words, buffers them
// in a show-ahead FIFO and presents them on a valid/ready bus with
// last / lane-count / error tags.
//
// Handshakes: a beat transfers on a rising clk_st edge where
// st_valid && st_ready; a word transfers where bus_valid && bus_ready.
// st_ready depends on registered state only. bus_* hold steady while
// bus_valid && !bus_ready, except that a truncation arriving right after
// a lane-fill push may set last/err on a still-buffered newest word.
module st2bus_packer
  import st2bus_pkg::*;
#(
  parameter  int ST_W       = 8,
  parameter  int BUS_W      = 512,
  parameter  int FIFO_DEPTH = 8,
  localparam int LANES      = BUS_W / ST_W,
  localparam int LANE_W     = $clog2(LANES + 1),
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_st,
  input  logic              rst_n,
  input  logic [ST_W-1:0]   st_data,
  input  logic              st_valid,
  input  logic              st_sop,
  input  logic              st_eop,
  output logic              st_ready,
  output logic [BUS_W-1:0]  bus_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_last,
  output logic [LANE_W-1:0] bus_nbeats,
  output logic              bus_err,
  output logic              err_orphan,
  output logic [LVL_W-1:0]  fifo_level,
  output pk_state_e         dbg_state
);

  pk_state_e         state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [BUS_W-1:0]  pack_q, pack_d;
  logic              rdy_en_q;
  logic              orphan_q, orphan_d;

  logic              accept;
  logic [BUS_W-1:0]  beat_word;
  logic [BUS_W-1:0]  lane0_word;

  logic              push;
  logic              retag;
  logic [BUS_W-1:0]  push_data;
  word_tag_t         push_tag;
  logic              pop;
  logic              fifo_empty;
  logic [BUS_W-1:0]  head_data;
  word_tag_t         head_tag;
  logic [LVL_W-1:0]  level;

  // The margin of two leaves room for a truncated word plus the deferred
  // one-beat packet that FLUSH pushes on the following cycle.
  assign st_ready = rdy_en_q && (state_q != ST_FLUSH) &&
                    (level <= LVL_W'(FIFO_DEPTH - 2));
  assign accept   = st_valid && st_ready;

  // Candidate words: the current packing register with the beat merged in
  // at the current lane, and a fresh word holding only this beat in lane 0.
  always_comb begin
    beat_word = pack_q;
    beat_word[int'(lane_q) * ST_W +: ST_W] = st_data;
    lane0_word = BUS_W'(st_data);
  end

  // Next-state, packing and push/retag decisions.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    push      = 1'b0;
    push_data = lane0_word;
    push_tag  = make_tag(1'b0, 1'b0, '0);
    retag     = 1'b0;
    orphan_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (st_sop && st_eop) begin
            push      = 1'b1;
            push_data = lane0_word;
            push_tag  = make_tag(1'b1, 1'b0, CNT_W'(1));
          end else if (st_sop) begin
            pack_d  = lane0_word;
            lane_d  = LANE_W'(1);
            state_d = ST_PKT;
          end else begin
            orphan_d = 1'b1;
          end
        end
      end
      ST_PKT: begin
        if (accept) begin
          if (st_sop) begin
            // Truncation: close the partial word, or tag the newest entry
            // when the partial word is empty.
            if (lane_q != '0) begin
              push      = 1'b1;
              push_data = pack_q;
              push_tag  = make_tag(1'b1, 1'b1, CNT_W'(lane_q));
            end else begin
              retag = 1'b1;
            end
            if (st_eop && (lane_q != '0)) begin
              // Push slot already used; emit the one-beat packet next cycle.
              pack_d  = lane0_word;
              lane_d  = LANE_W'(1);
              state_d = ST_FLUSH;
            end else if (st_eop) begin
              push      = 1'b1;
              push_data = lane0_word;
              push_tag  = make_tag(1'b1, 1'b0, CNT_W'(1));
              pack_d    = '0;
              lane_d    = '0;
              state_d   = ST_IDLE;
            end else begin
              pack_d = lane0_word;
              lane_d = LANE_W'(1);
            end
          end else if (st_eop || (lane_q == LANE_W'(LANES - 1))) begin
            push      = 1'b1;
            push_data = beat_word;
            push_tag  = make_tag(st_eop, 1'b0, CNT_W'(lane_q + LANE_W'(1)));
            pack_d    = '0;
            lane_d    = '0;
            if (st_eop) state_d = ST_IDLE;
          end else begin
            pack_d = beat_word;
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        push      = 1'b1;
        push_data = pack_q;
        push_tag  = make_tag(1'b1, 1'b0, CNT_W'(1));
        pack_d    = '0;
        lane_d    = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pack_d  = '0;
        lane_d  = '0;
      end
    endcase
  end

  // State, lane counter, packing register, ready enable and orphan pulse.
  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      pack_q   <= '0;
      rdy_en_q <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      rdy_en_q <= 1'b1;
      orphan_q <= orphan_d;
    end
  end

  st2bus_word_fifo #(
    .W     (BUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_st),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .push_tag  (push_tag),
    .pop       (pop),
    .retag     (retag),
    .head_data (head_data),
    .head_tag  (head_tag),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign bus_valid  = !fifo_empty;
  assign pop        = bus_valid && bus_ready;
  assign bus_data   = bus_valid ? head_data : '0;
  assign bus_last   = bus_valid && head_tag.last;
  assign bus_err    = bus_valid && head_tag.err;
  assign bus_nbeats = bus_valid ? LANE_W'(head_tag.nbeats) : '0;
  assign err_orphan = orphan_q;
  assign fifo_level = level;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_st2bus_packer.sv
// Bench for st2bus_packer: directed packets with hand-computed word
// expectations plus randomized traffic, all checked every cycle against a
// packet-level reference model of the packing rules.
module tb_st2bus_packer;
  import st2bus_pkg::*;

  localparam int ST_W  = 8;
  localparam int BUS_W = 512;
  localparam int DEPTH = 8;
  localparam int NB    = BUS_W / ST_W;
  localparam int TW    = BUS_W + 2 + CNT_W;   // {err, last, nbeats, data}

  // ---------------- clock / reset / DUT ----------------
  logic             clk_st = 1'b0;
  logic             rst_n  = 1'b0;
  logic [ST_W-1:0]  st_data = '0;
  logic             st_valid = 1'b0;
  logic             st_sop = 1'b0;
  logic             st_eop = 1'b0;
  logic             st_ready;
  logic [BUS_W-1:0] bus_data;
  logic             bus_valid;
  logic             bus_ready = 1'b0;
  logic             bus_last;
  logic [CNT_W-1:0] bus_nbeats;
  logic             bus_err;
  logic             err_orphan;
  logic [3:0]       fifo_level;
  pk_state_e        dbg_state;

  always #5 clk_st = ~clk_st;

  st2bus_packer #(.ST_W(ST_W), .BUS_W(BUS_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_st     (clk_st),
    .rst_n      (rst_n),
    .st_data    (st_data),
    .st_valid   (st_valid),
    .st_sop     (st_sop),
    .st_eop     (st_eop),
    .st_ready   (st_ready),
    .bus_data   (bus_data),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_last   (bus_last),
    .bus_nbeats (bus_nbeats),
    .bus_err    (bus_err),
    .err_orphan (err_orphan),
    .fifo_level (fifo_level),
    .dbg_state  (dbg_state)
  );

  // bus_ready policy: 0 = stalled, 1 = always ready, 2 = random.
  int ready_mode = 0;
  always @(posedge clk_st) begin
    #1;
    case (ready_mode)
      0:       bus_ready = 1'b0;
      1:       bus_ready = 1'b1;
      default: bus_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- counters and checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [TW-1:0] mk(input bit err, input bit last, input int nb,
                                       input logic [BUS_W-1:0] d);
    return {err, last, CNT_W'(nb), d};
  endfunction

  // Word whose first n lanes hold base, base+1, ... (mod 256), rest zero.
  function automatic logic [BUS_W-1:0] seq_data(input int base, input int n);
    logic [BUS_W-1:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[k*ST_W +: ST_W] = 8'(base + k);
    return d;
  endfunction

  // ---------------- reference model ----------------
  logic [TW-1:0]   exp_q[$];     // words expected in the FIFO, head first
  logic [ST_W-1:0] cur_q[$];     // beats of the word being assembled
  logic [TW-1:0]   got_q[$];     // words observed leaving the bus
  bit              in_pkt = 0;
  bit              flush_pend = 0;
  logic [ST_W-1:0] flush_beat = '0;
  bit              rdy_en = 0;
  bit              exp_rdy = 0;
  bit              exp_orph = 0;
  bit              model_ok = 0;
  int              orphan_seen = 0;

  function automatic logic [TW-1:0] word_from_cur(input bit err, input bit last);
    logic [BUS_W-1:0] d;
    d = '0;
    for (int k = 0; k < cur_q.size(); k++) d[k*ST_W +: ST_W] = cur_q[k];
    return mk(err, last, cur_q.size(), d);
  endfunction

  function automatic logic [TW-1:0] one_beat(input logic [ST_W-1:0] b);
    return mk(1'b0, 1'b1, 1, BUS_W'(b));
  endfunction

  // Applies one clock edge worth of traffic to the model.
  task automatic model_step(input bit acc, input bit popd);
    logic [TW-1:0] t;
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      in_pkt = 0; flush_pend = 0; rdy_en = 0; exp_orph = 0; model_ok = 1;
    end else if (model_ok) begin
      exp_orph = 0;
      if (popd && exp_q.size() > 0) exp_q.delete(0);
      if (flush_pend) begin
        exp_q.push_back(one_beat(flush_beat));
        flush_pend = 0;
      end else if (acc) begin
        if (!in_pkt) begin
          if (st_sop && st_eop) exp_q.push_back(one_beat(st_data));
          else if (st_sop) begin cur_q.push_back(st_data); in_pkt = 1; end
          else exp_orph = 1;
        end else if (st_sop) begin
          if (cur_q.size() > 0) begin
            exp_q.push_back(word_from_cur(1'b1, 1'b1));
            cur_q.delete();
            if (st_eop) begin flush_pend = 1; flush_beat = st_data; in_pkt = 0; end
            else cur_q.push_back(st_data);
          end else begin
            if (exp_q.size() > 0) begin
              t = exp_q[exp_q.size()-1];
              t[TW-1] = 1'b1;
              t[TW-2] = 1'b1;
              exp_q[exp_q.size()-1] = t;
            end
            if (st_eop) begin exp_q.push_back(one_beat(st_data)); in_pkt = 0; end
            else cur_q.push_back(st_data);
          end
        end else begin
          cur_q.push_back(st_data);
          if (st_eop || cur_q.size() == NB) begin
            exp_q.push_back(word_from_cur(1'b0, st_eop));
            cur_q.delete();
            if (st_eop) in_pkt = 0;
          end
        end
      end
      rdy_en = 1;
    end
    exp_rdy = rdy_en && (exp_q.size() <= DEPTH - 2) && !flush_pend;
  endtask

  // Scoreboard: compare on the falling edge, then advance the model.
  always @(negedge clk_st) begin : scoreboard
    bit acc, popd;
    if (model_ok) begin
      check("st_ready",   TW'(st_ready),   TW'(exp_rdy));
      check("fifo_level", TW'(fifo_level), TW'(exp_q.size()));
      check("err_orphan", TW'(err_orphan), TW'(exp_orph));
      check("bus_valid",  TW'(bus_valid),  TW'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        check("bus_word", {bus_err, bus_last, bus_nbeats, bus_data}, exp_q[0]);
      else
        check("bus_idle", {bus_err, bus_last, bus_nbeats, bus_data}, '0);
    end
    if (bus_valid && bus_ready) got_q.push_back({bus_err, bus_last, bus_nbeats, bus_data});
    if (err_orphan) orphan_seen++;
    acc  = st_valid && st_ready;
    popd = bus_valid && bus_ready;
    model_step(acc, popd);
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk_st);
    #1;
  endtask

  task automatic send(input logic [ST_W-1:0] d, input bit sop, input bit eop);
    int waited = 0;
    st_data = d; st_sop = sop; st_eop = eop; st_valid = 1'b1;
    forever begin
      @(negedge clk_st);
      if (st_ready) begin
        sync();
        break;
      end
      waited++;
      if (waited > 2000) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: st_ready low for %0d cycles, want high", waited);
        sync();
        break;
      end
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int base, input bit eop, input bit gaps);
    for (int i = 0; i < len; i++) begin
      send(8'(base + i), i == 0, eop && (i == len - 1));
      if (gaps && $urandom_range(0, 7) == 0) sync();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    repeat (2) @(negedge clk_st);
    while ((bus_valid || fifo_level != 0) && n < 5000) begin
      @(negedge clk_st);
      n++;
    end
    check("drain_timeout", TW'(n >= 5000), '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) sync();
    rst_n = 1'b1;

    // Reset state: st_ready low for exactly one cycle.
    @(negedge clk_st);
    check("rst_ready", TW'(st_ready), '0);
    check("rst_level", TW'(fifo_level), '0);
    check("rst_valid", TW'({bus_valid, bus_last, bus_err, err_orphan}), '0);
    @(negedge clk_st);
    check("ready_after_rst", TW'(st_ready), TW'(1));
    sync();

    // 128-beat packet -> two full words.
    ready_mode = 1;
    got_q.delete();
    send_pkt(128, 0, 1, 0);
    wait_drain();
    check("p128_count", TW'(got_q.size()), TW'(2));
    check("p128_w0", got_q[0], mk(0, 0, 64, seq_data(0, 64)));
    check("p128_w1", got_q[1], mk(0, 1, 64, seq_data(64, 64)));
    sync();

    // 70-beat packet, then a sop&eop single beat.
    got_q.delete();
    send_pkt(70, 0, 1, 0);
    send(8'hA5, 1, 1);
    wait_drain();
    check("p70_count", TW'(got_q.size()), TW'(3));
    check("p70_w1", got_q[1], mk(0, 1, 6, seq_data(64, 6)));
    check("single_a5", got_q[2], mk(0, 1, 1, BUS_W'(8'hA5)));
    sync();

    // Backpressure: 1024 beats with bus_ready held low at first.
    ready_mode = 0;
    got_q.delete();
    fork
      send_pkt(1024, 0, 1, 0);
      begin : releaser
        int n = 0;
        do begin @(negedge clk_st); n++; end
          while (!(fifo_level == 4'd7 && !st_ready) && n < 3000);
        check("bp_reached", TW'(n >= 3000), '0);
        repeat (30) @(negedge clk_st);
        check("bp_hold_level", TW'(fifo_level), TW'(7));
        check("bp_hold_ready", TW'(st_ready), '0);
        ready_mode = 1;
      end
    join
    wait_drain();
    check("bp_count", TW'(got_q.size()), TW'(16));
    for (int w = 0; w < 16; w++)
      check($sformatf("bp_w%0d", w), got_q[w], mk(0, w == 15, 64, seq_data(w * 64, 64)));
    sync();

    // Truncation by sop at beat 10; new packet completes cleanly.
    got_q.delete();
    send_pkt(10, 8'h10, 0, 0);
    send_pkt(20, 8'h80, 1, 0);
    wait_drain();
    check("trunc_count", TW'(got_q.size()), TW'(2));
    check("trunc_w0", got_q[0], mk(1, 1, 10, seq_data(8'h10, 10)));
    check("trunc_w1", got_q[1], mk(0, 1, 20, seq_data(8'h80, 20)));
    sync();

    // Truncation right after a lane-fill push retags the buffered word.
    ready_mode = 0;
    got_q.delete();
    send_pkt(64, 0, 0, 0);
    send_pkt(5, 8'h40, 1, 0);
    ready_mode = 1;
    wait_drain();
    check("retag_count", TW'(got_q.size()), TW'(2));
    check("retag_w0", got_q[0], mk(1, 1, 64, seq_data(0, 64)));
    check("retag_w1", got_q[1], mk(0, 1, 5, seq_data(8'h40, 5)));
    sync();

    // Truncation by a sop&eop beat: truncated word then the one-beat packet.
    got_q.delete();
    send_pkt(3, 8'h20, 0, 0);
    send(8'h99, 1, 1);
    wait_drain();
    check("flush_count", TW'(got_q.size()), TW'(2));
    check("flush_w0", got_q[0], mk(1, 1, 3, seq_data(8'h20, 3)));
    check("flush_w1", got_q[1], mk(0, 1, 1, BUS_W'(8'h99)));
    sync();

    // Orphan beats while idle.
    got_q.delete();
    orphan_seen = 0;
    send(8'h01, 0, 0);
    send(8'h02, 0, 0);
    send(8'h03, 0, 0);
    repeat (3) sync();
    @(negedge clk_st);
    check("orphan_pulses", TW'(orphan_seen), TW'(3));
    check("orphan_level", TW'(fifo_level), '0);
    check("orphan_words", TW'(got_q.size()), '0);
    sync();

    // Reset mid-packet with a word still buffered.
    ready_mode = 0;
    send_pkt(64 + 30, 0, 0, 0);
    do_reset();
    @(negedge clk_st);
    check("midrst_valid", TW'(bus_valid), '0);
    check("midrst_level", TW'(fifo_level), '0);
    sync();
    ready_mode = 1;
    got_q.delete();
    send_pkt(64, 8'h33, 1, 0);
    wait_drain();
    check("midrst_count", TW'(got_q.size()), TW'(1));
    check("midrst_w0", got_q[0], mk(0, 1, 64, seq_data(8'h33, 64)));
    sync();

    // Randomized traffic with random backpressure and valid gaps.
    ready_mode = 2;
    for (int p = 0; p < 60; p++) begin
      int r, len;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        repeat ($urandom_range(1, 3)) send(8'($urandom), 0, 0);
      end
      if (r % 5 == 0) len = 64 * $urandom_range(1, 2);
      else if (r % 7 == 0) len = 1;
      else len = $urandom_range(1, 150);
      send_pkt(len, $urandom_range(0, 255), $urandom_range(0, 9) != 0, 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
    end
    ready_mode = 1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
